ctrl_pipe: RTL
==============

// Module: ctrl_pipe
// PURPOSE
//  Next-generation pipelined controller for the 5-stage MIPS core.
//  - Decodes the D-stage instruction; carries control bundles through registered D/E, E/M, M/W stages.
//  - Computes Tuse/Tnew hazard stalls and forwarding selects.
//  - Optional multi-cycle MDU tracking; replaces per-stage copies of the combinational decoder.
// PARAMETERS
//  REG_AW    5   register-file address width (dst/src fields)
//  MULT_LAT  5   MDU busy cycles for mult/multu (CTRL_MDU_EN only)
//  DIV_LAT   10  MDU busy cycles for div/divu (CTRL_MDU_EN only)
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-low reset
//  instr_d       in   32      instruction in D stage
//  d_npc_sel     out  2       0 PC+4, 1 branch/j/jal target, 2 rs (jr/jalr)
//  d_ext_op      out  2       0 zero, 1 sign, 2 high(lui)
//  d_cmp_op      out  2       0 none, 1 beq, 2 bne
//  stall         out  1       freeze PC and F/D, bubble into E
//  e_alu_op      out  4       ALU function for E-stage instruction
//  e_alu_src     out  1       1 = immediate operand
//  m_mem_we      out  1       data-memory write enable (M stage)
//  w_reg_we      out  1       register write enable (W stage)
//  w_wb_sel      out  2       0 ALU result, 1 mem data, 2 PC+8, 3 HI/LO
//  w_dst         out  REG_AW  destination register in W
//  d_fwd_rs/rt   out  2 each  0 RF, 1 from E(PC+8), 2 from M result, 3 from W
//  e_fwd_rs/rt   out  2 each  0 pipeline reg, 2 from M, 3 from W
//  m_fwd_rt      out  1       1 = store data from W
//  mdu_start     out  1       one-cycle start pulse to MDU (CTRL_MDU_EN only)
// BEHAVIOUR
//  - Decode set:
//    - R-type: addu subu slt sll jr jalr.
//    - I/J-type: ori lui addiu lw sw beq bne j jal.
//    - Unknown encodings decode as nop; nop = all-zero control, dst 0.
//  - Stage registers E, M, W each hold {alu_op, alu_src, mem_we, reg_we, wb_sel, dst, tnew}.
//    - Advance every clk.
//    - On stall, E loads the nop bundle while D holds.
//  - dst: rd for R-type, rt for I-type ALU/lw, 31 for jal. jalr uses rd.
//    - Writes to reg 0 are forced to reg_we=0, dst=0.
//  - Tnew at E entry: ALU=1, lw=2, jal/jalr=0, others 0. Decremented, saturating at 0, per stage.
//  - Tuse:
//    - rs: beq/bne/jr/jalr=0; ALU/lw/sw=1.
//    - rt: beq/bne=0, R-type ALU=1, sw=2.
//  - stall=1 iff some source reg r!=0 is used and matches E.dst or M.dst with reg_we, and Tuse < that stage's Tnew.
//    - E has priority over M in the match.
//  - Forwarding selects the youngest matching stage with reg_we, dst!=0 and Tnew==0.
//  - Outputs during reset: all stage bundles nop, stall=0, fwd=0, mdu_start=0.
//    - Reset mid-stall clears all state next edge.
//  - Combinational outputs: d_* decode outputs and fwd selects. Registered outputs: e_*/m_*/w_*.
// CONFIGURATION
//  - CTRL_MDU_EN defined:
//    - Adds mult multu div divu mfhi mflo mthi mtlo.
//    - A down-counter busy_cnt loads MULT_LAT/DIV_LAT when a mult/div enters E (mdu_start=1 that cycle).
//    - Any MDU instruction in D stalls while busy_cnt!=0 or mdu_start=1.
//    - mfhi/mflo: wb_sel=3, Tnew=1.
//    - A new mult/div is never issued while busy.
//  - CTRL_MDU_EN undefined: MDU opcodes decode as nop; mdu_start tied 0; no counter.
// STRUCTURE
//  - Package ctrl_pkg: opcode/funct localparams, NPC_*/EXT_*/ALU_*/WB_*/FWD_* encodings, ctrl_bundle_t struct, NOP_BUNDLE constant.
//  - Sub-module ctrl_decode: pure combinational instr -> bundle + Tuse.
//    - Instantiated once in D.
//    - Hazard/forward logic and stage registers live in ctrl_pipe.
// TESTING
//  1. reset=0 for 2 cycles, then stream addu $3,$1,$2 -> all outputs 0 during reset; w_reg_we=1, w_dst=3 exactly 3 cycles after D.
//  2. lw $4,0($0) then addu $5,$4,$4 -> stall=1 for exactly 1 cycle; then e_fwd_rs=e_fwd_rt=3 (from W).
//  3. ori $6,$0,1 then beq $6,$0,x -> 1 stall cycle; then d_fwd_rs=2 (from M), d_cmp_op=1.
//  4. jal x then sw $31,0($0) -> no stall; $31 forwarded via PC+8; jal to $0 never asserts w_reg_we.
//  5. lui $0,5 then addu $7,$0,$0 -> no stall, no forwarding (reg 0 rule).
//  6. CTRL_MDU_EN, MULT_LAT=5: mult then mflo -> mdu_start pulse 1 cycle; mflo stalls 5 cycles; w_wb_sel=3.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings, control bundle type and hazard helpers for ctrl_pipe.
// Optional MDU support is enabled by defining CTRL_MDU_EN.
package ctrl_pkg;

    localparam int RAW = 5;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_TGT  = 2'd1;
    localparam logic [1:0] NPC_RS   = 2'd2;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_HIGH = 2'd2;

    localparam logic [1:0] CMP_NONE = 2'd0;
    localparam logic [1:0] CMP_BEQ  = 2'd1;
    localparam logic [1:0] CMP_BNE  = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLL  = 4'd4;

    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC8   = 2'd2;
    localparam logic [1:0] WB_HILO  = 2'd3;

    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_W    = 2'd3;

    typedef struct packed {
        logic [3:0]     alu_op;
        logic           alu_src;
        logic           mem_we;
        logic           reg_we;
        logic [1:0]     wb_sel;
        logic [RAW-1:0] dst;
        logic [1:0]     tnew;
    } ctrl_bundle_t;

    typedef struct packed {
        logic [1:0] npc_sel;
        logic [1:0] ext_op;
        logic [1:0] cmp_op;
        logic       use_rs;
        logic       use_rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic       mdu;
        logic       mdu_start;
        logic       mdu_div;
    } dec_info_t;

    localparam ctrl_bundle_t NOP_BUNDLE = '0;

    function automatic ctrl_bundle_t age(input ctrl_bundle_t b);
        ctrl_bundle_t r;
        r = b;
        if (b.tnew != 2'd0) r.tnew = b.tnew - 2'd1;
        return r;
    endfunction

    function automatic logic hit(input ctrl_bundle_t b,
                                 input logic [RAW-1:0] src);
        return b.reg_we && (b.dst == src) && (b.tnew == 2'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [RAW-1:0] src,
                                           input logic allow_e,
                                           input ctrl_bundle_t e,
                                           input ctrl_bundle_t m,
                                           input ctrl_bundle_t w);
        if (src == '0) return FWD_RF;
        if (allow_e && hit(e, src)) return FWD_E;
        if (hit(m, src)) return FWD_M;
        if (hit(w, src)) return FWD_W;
        return FWD_RF;
    endfunction

    // Source not ready in time: youngest writer decides, E before M.
    function automatic logic late(input logic [RAW-1:0] src,
                                  input logic [1:0] tuse,
                                  input ctrl_bundle_t e,
                                  input ctrl_bundle_t m);
        if (src == '0) return 1'b0;
        if (e.reg_we && e.dst == src) return tuse < e.tnew;
        if (m.reg_we && m.dst == src) return tuse < m.tnew;
        return 1'b0;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational D-stage decoder: instruction -> control bundle + Tuse info.
// MDU opcodes are recognised only when CTRL_MDU_EN is defined.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t bundle,
    output dec_info_t    info
);

    logic [5:0]     op;
    logic [5:0]     fn;
    logic [RAW-1:0] rt;
    logic [RAW-1:0] rd;
    logic           r;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign rt = instr[20:16];
    assign rd = instr[15:11];
    // The all-zero word is the canonical nop, not an sll.
    assign r  = (op == OP_R) && (instr != 32'h0);

    // Table decode; anything unrecognised stays a nop.
    always_comb begin
        bundle = NOP_BUNDLE;
        info   = '0;
        unique case (1'b1)
            r && (fn == FN_ADDU || fn == FN_SUBU || fn == FN_SLT): begin
                bundle.alu_op = (fn == FN_SUBU) ? ALU_SUB :
                                (fn == FN_SLT)  ? ALU_SLT : ALU_ADD;
                bundle.reg_we = 1'b1;
                bundle.dst    = rd;
                bundle.tnew   = 2'd1;
                info.use_rs   = 1'b1;
                info.use_rt   = 1'b1;
                info.tuse_rs  = 2'd1;
                info.tuse_rt  = 2'd1;
            end
            r && (fn == FN_SLL): begin
                bundle.alu_op = ALU_SLL;
                bundle.reg_we = 1'b1;
                bundle.dst    = rd;
                bundle.tnew   = 2'd1;
                info.use_rt   = 1'b1;
                info.tuse_rt  = 2'd1;
            end
            r && (fn == FN_JR): begin
                info.npc_sel  = NPC_RS;
                info.use_rs   = 1'b1;
            end
            r && (fn == FN_JALR): begin
                info.npc_sel  = NPC_RS;
                info.use_rs   = 1'b1;
                bundle.reg_we = 1'b1;
                bundle.wb_sel = WB_PC8;
                bundle.dst    = rd;
            end
`ifdef CTRL_MDU_EN
            r && (fn == FN_MULT || fn == FN_MULTU ||
                  fn == FN_DIV  || fn == FN_DIVU): begin
                info.use_rs    = 1'b1;
                info.use_rt    = 1'b1;
                info.tuse_rs   = 2'd1;
                info.tuse_rt   = 2'd1;
                info.mdu       = 1'b1;
                info.mdu_start = 1'b1;
                info.mdu_div   = (fn == FN_DIV) || (fn == FN_DIVU);
            end
            r && (fn == FN_MTHI || fn == FN_MTLO): begin
                info.use_rs   = 1'b1;
                info.tuse_rs  = 2'd1;
                info.mdu      = 1'b1;
            end
            r && (fn == FN_MFHI || fn == FN_MFLO): begin
                bundle.reg_we = 1'b1;
                bundle.wb_sel = WB_HILO;
                bundle.dst    = rd;
                bundle.tnew   = 2'd1;
                info.mdu      = 1'b1;
            end
`endif
            op == OP_J: begin
                info.npc_sel  = NPC_TGT;
            end
            op == OP_JAL: begin
                info.npc_sel  = NPC_TGT;
                bundle.reg_we = 1'b1;
                bundle.wb_sel = WB_PC8;
                bundle.dst    = RAW'(31);
            end
            op == OP_BEQ || op == OP_BNE: begin
                info.npc_sel  = NPC_TGT;
                info.ext_op   = EXT_SIGN;
                info.cmp_op   = (op == OP_BEQ) ? CMP_BEQ : CMP_BNE;
                info.use_rs   = 1'b1;
                info.use_rt   = 1'b1;
            end
            op == OP_ORI || op == OP_ADDIU: begin
                bundle.alu_op  = (op == OP_ORI) ? ALU_OR : ALU_ADD;
                bundle.alu_src = 1'b1;
                bundle.reg_we  = 1'b1;
                bundle.dst     = rt;
                bundle.tnew    = 2'd1;
                info.ext_op    = (op == OP_ORI) ? EXT_ZERO : EXT_SIGN;
                info.use_rs    = 1'b1;
                info.tuse_rs   = 2'd1;
            end
            op == OP_LUI: begin
                bundle.alu_op  = ALU_ADD;
                bundle.alu_src = 1'b1;
                bundle.reg_we  = 1'b1;
                bundle.dst     = rt;
                bundle.tnew    = 2'd1;
                info.ext_op    = EXT_HIGH;
            end
            op == OP_LW: begin
                bundle.alu_op  = ALU_ADD;
                bundle.alu_src = 1'b1;
                bundle.reg_we  = 1'b1;
                bundle.wb_sel  = WB_MEM;
                bundle.dst     = rt;
                bundle.tnew    = 2'd2;
                info.ext_op    = EXT_SIGN;
                info.use_rs    = 1'b1;
                info.tuse_rs   = 2'd1;
            end
            op == OP_SW: begin
                bundle.alu_op  = ALU_ADD;
                bundle.alu_src = 1'b1;
                bundle.mem_we  = 1'b1;
                info.ext_op    = EXT_SIGN;
                info.use_rs    = 1'b1;
                info.use_rt    = 1'b1;
                info.tuse_rs   = 2'd1;
                info.tuse_rt   = 2'd2;
            end
            default: ;
        endcase
        if (bundle.dst == '0) bundle.reg_we = 1'b0;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined controller: D decode, E/M/W control bundles, stalls, forwarding.
// Define CTRL_MDU_EN to add multiply/divide tracking and mdu_start.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_d,
    output logic [1:0]        d_npc_sel,
    output logic [1:0]        d_ext_op,
    output logic [1:0]        d_cmp_op,
    output logic              stall,
    output logic [3:0]        e_alu_op,
    output logic              e_alu_src,
    output logic              m_mem_we,
    output logic              w_reg_we,
    output logic [1:0]        w_wb_sel,
    output logic [REG_AW-1:0] w_dst,
    output logic [1:0]        d_fwd_rs,
    output logic [1:0]        d_fwd_rt,
    output logic [1:0]        e_fwd_rs,
    output logic [1:0]        e_fwd_rt,
    output logic              m_fwd_rt,
    output logic              mdu_start
);

    ctrl_bundle_t   d_b, e_q, m_q, w_q;
    dec_info_t      d_i;
    logic [RAW-1:0] rs_src, rt_src;
    logic [RAW-1:0] e_rs, e_rt, m_rt;
    logic           stall_raw, mdu_stall;

    ctrl_decode u_dec (
        .instr  (instr_d),
        .bundle (d_b),
        .info   (d_i)
    );

    assign rs_src = d_i.use_rs ? instr_d[25:21] : '0;
    assign rt_src = d_i.use_rt ? instr_d[20:16] : '0;

    assign stall_raw = late(rs_src, d_i.tuse_rs, e_q, m_q)
                     | late(rt_src, d_i.tuse_rt, e_q, m_q)
                     | mdu_stall;

    assign stall     = reset & stall_raw;
    assign d_npc_sel = d_i.npc_sel;
    assign d_ext_op  = d_i.ext_op;
    assign d_cmp_op  = d_i.cmp_op;
    assign d_fwd_rs  = reset ? fwd_sel(rs_src, 1'b1, e_q, m_q, w_q) : FWD_RF;
    assign d_fwd_rt  = reset ? fwd_sel(rt_src, 1'b1, e_q, m_q, w_q) : FWD_RF;
    assign e_fwd_rs  = reset ? fwd_sel(e_rs, 1'b0, e_q, m_q, w_q) : FWD_RF;
    assign e_fwd_rt  = reset ? fwd_sel(e_rt, 1'b0, e_q, m_q, w_q) : FWD_RF;
    assign m_fwd_rt  = reset && m_q.mem_we && (m_rt != '0) && hit(w_q, m_rt);

    assign e_alu_op  = e_q.alu_op;
    assign e_alu_src = e_q.alu_src;
    assign m_mem_we  = m_q.mem_we;
    assign w_reg_we  = w_q.reg_we;
    assign w_wb_sel  = w_q.wb_sel;
    assign w_dst     = REG_AW'(w_q.dst);

    // Advance the control bundles each cycle; a stall bubbles E.
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q  <= NOP_BUNDLE;
            m_q  <= NOP_BUNDLE;
            w_q  <= NOP_BUNDLE;
            e_rs <= '0;
            e_rt <= '0;
            m_rt <= '0;
        end else begin
            e_q  <= stall ? NOP_BUNDLE : d_b;
            e_rs <= stall ? '0 : rs_src;
            e_rt <= stall ? '0 : rt_src;
            m_q  <= age(e_q);
            m_rt <= e_rt;
            w_q  <= age(m_q);
        end
    end

    logic unused_w;
    assign unused_w = ^{w_q.alu_op, w_q.alu_src, w_q.mem_we};

`ifdef CTRL_MDU_EN
    localparam int LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(LAT_MAX + 1);

    logic [CW-1:0] busy_cnt;
    logic          start_q;

    // Busy counter armed as a mult/div is issued into E.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_cnt <= '0;
            start_q  <= 1'b0;
        end else begin
            start_q <= !stall && d_i.mdu_start;
            if (!stall && d_i.mdu_start)
                busy_cnt <= d_i.mdu_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - CW'(1);
        end
    end

    assign mdu_stall = d_i.mdu && ((busy_cnt != '0) || start_q);
    assign mdu_start = reset & start_q;
`else
    assign mdu_stall = 1'b0;
    assign mdu_start = 1'b0;

    logic unused_mdu;
    assign unused_mdu = ^{d_i.mdu, d_i.mdu_start, d_i.mdu_div}
                      ^ ((MULT_LAT + DIV_LAT) != 0);
`endif

endmodule
